// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package md_pkg;

  // EX-stage md opcode encodings; values 6 and 7 are no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default busy times.
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  // Multi-cycle ops are exactly the encodings 0..3.
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Ops 2/3 are the divides.
  function automatic logic md_is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder from the latched op and operands.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  logic        w_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);

  // Low 64 bits of the product of sign/zero-extended operands give both MULT and MULTU.
  assign w_ext_a = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
  assign w_ext_b = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign w_neg_a = w_signed & i_a[31];
  assign w_neg_b = w_signed & i_b[31];
  assign w_mag_a = w_neg_a ? (32'd0 - i_a) : i_a;
  assign w_mag_b = w_neg_b ? (32'd0 - i_b) : i_b;
  // Substitute a harmless divisor on zero; the result is discarded anyway.
  assign w_den   = (i_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_mag_q = w_mag_a / w_den;
  assign w_mag_r = w_mag_a % w_den;
  assign w_quot  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_rem   = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;

  // Select product or quotient/remainder for HI/LO.
  always_comb begin
    o_hi       = w_rem;
    o_lo       = w_quot;
    o_div_zero = 1'b0;
    if (md_is_div(i_op)) begin
      o_div_zero = (i_b == 32'd0);
    end else begin
      o_hi = w_prod[63:32];
      o_lo = w_prod[31:0];
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs multi-cycle md ops, requests stalls for ID.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_md_use_d,
  output logic        o_busy,
  output logic        o_stall_req,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e         r_state;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic [31:0]       w_res_hi;
  logic [31:0]       w_res_lo;
  logic              w_div_zero;

  md_arith u_arith (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_hi       (w_res_hi),
    .o_lo       (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  // FSM: launch from idle, count down in run, commit HI/LO on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (md_is_arith(i_op)) begin
              r_op    <= i_op;
              r_a     <= i_src_a;
              r_b     <= i_src_b;
              r_cnt   <= md_is_div(i_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
              r_busy  <= 1'b1;
              r_state <= StRun;
            end else if (i_op == MD_MTHI) begin
              r_hi <= i_src_a;
            end else if (i_op == MD_MTLO) begin
              r_lo <= i_src_a;
            end
          end
        end
        StRun: begin
          // Any start seen here is a hazard-unit bug and is deliberately dropped.
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            if (!w_div_zero) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Stall the ID md instruction while busy and on the launch cycle itself.
  assign o_stall_req = i_md_use_d & (r_busy | (i_start & md_is_arith(i_op)));

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
